// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: default widths,
// the x0 address and the grant encoding used by the arbiter's history bit.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam int unsigned ZERO_REG = 0;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester arbiter: round-robin on conflict, or mem-always-wins when
// FIXED_PRIO is set. Grant is one-hot, bit index = grant_e encoding.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  grant_e last_grant;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (req[GRANT_ALU] && req[GRANT_MEM]) begin
        if (FIXED_PRIO || (last_grant == GRANT_ALU)) grant[GRANT_MEM] = 1'b1;
        else                                         grant[GRANT_ALU] = 1'b1;
      end else begin
        grant = req;
      end
    end
  end

  // Every grant is a transfer: ready is the grant, and grant implies valid.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GRANT_MEM;
    end else if (|grant) begin
      last_grant <= grant[GRANT_MEM] ? GRANT_MEM : GRANT_ALU;
    end
  end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and load writeback, drops x0
// writes, and forwards the write held in the output stage to two queries.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_load,
  output logic [ADDR_W-1:0] rf_w_address,
  output logic [DATA_W-1:0] rf_w_in,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q1_hit,
  output logic              q2_hit,
  output logic [DATA_W-1:0] fwd_data
);

  logic [1:0]        grant;
  logic              transfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              sel_writes;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({mem_valid, alu_valid}),
    .grant (grant)
  );

  assign alu_ready = grant[GRANT_ALU];
  assign mem_ready = grant[GRANT_MEM];
  assign transfer  = |grant;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (grant[GRANT_MEM]) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end
  end

  // x0 requests are still accepted so the source never stalls on them.
  assign sel_writes = transfer && (sel_rd != ADDR_W'(ZERO_REG));

  // Address and data only move on a real write, so forwarding data stays
  // meaningful and the bus toggles less; rf_load alone qualifies them.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_load      <= 1'b0;
      rf_w_address <= '0;
      rf_w_in      <= '0;
    end else begin
      rf_load <= sel_writes;
      if (sel_writes) begin
        rf_w_address <= sel_rd;
        rf_w_in      <= sel_data;
      end
    end
  end

  assign q1_hit   = rf_load && (q1_addr == rf_w_address);
  assign q2_hit   = rf_load && (q2_addr == rf_w_address);
  assign fwd_data = rf_w_in;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: a behavioural arbiter model pushes the expected
// output-stage contents to a scoreboard each cycle; tasks pop and compare.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd, q1_addr, q2_addr;
  logic [31:0] alu_data, mem_data;

  logic        alu_ready, mem_ready, rf_load, q1_hit, q2_hit;
  logic [4:0]  rf_w_address;
  logic [31:0] rf_w_in, fwd_data;

  logic        fp_alu_ready, fp_mem_ready, fp_rf_load, fp_q1_hit, fp_q2_hit;
  logic [4:0]  fp_rf_w_address;
  logic [31:0] fp_rf_w_in, fp_fwd_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic        load;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  sb[$];
  logic m_last;  // 0 = ALU, 1 = MEM, model of the round-robin history

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b0)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_load(rf_load), .rf_w_address(rf_w_address), .rf_w_in(rf_w_in),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .fwd_data(fwd_data)
  );

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b1)) dut_fp (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(fp_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(fp_mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_load(fp_rf_load), .rf_w_address(fp_rf_w_address), .rf_w_in(fp_rf_w_in),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(fp_q1_hit), .q2_hit(fp_q2_hit),
    .fwd_data(fp_fwd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {mem_ready, alu_ready} for the round-robin instance.
  function automatic logic [1:0] model_grant();
    if (reset)                   return 2'b00;
    if (alu_valid && mem_valid)  return m_last ? 2'b01 : 2'b10;
    return {mem_valid, alu_valid};
  endfunction

  // Advance one clock; record what the output stage must hold afterwards.
  task automatic tick();
    logic [1:0] g;
    wr_t        e;
    g = model_grant();
    @(posedge clock);
    e = '0;
    if (reset) begin
      m_last = 1'b1;
    end else if (g[0]) begin
      m_last = 1'b0;
      e.load = (alu_rd != 5'd0);
      e.addr = alu_rd;
      e.data = alu_data;
    end else if (g[1]) begin
      m_last = 1'b1;
      e.load = (mem_rd != 5'd0);
      e.addr = mem_rd;
      e.data = mem_data;
    end
    sb.push_back(e);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    q1_addr = '0; q2_addr = '0;
  endtask

  task automatic test_reset();
    wr_t e;
    idle_inputs();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      #1;
      total_cnt++;
      if ({mem_ready, alu_ready} !== 2'b00)
        $display("FAIL reset_ready[%0d]: got %b want 00", i, {mem_ready, alu_ready});
      else pass_cnt++;
      total_cnt++;
      if (rf_load !== e.load)
        $display("FAIL reset_rf_load[%0d]: got %b want %b", i, rf_load, e.load);
      else pass_cnt++;
    end
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({mem_ready, alu_ready} !== 2'b01)
      $display("FAIL reset_first_grant: got %b want 01", {mem_ready, alu_ready});
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (alu_ready === 1'b0 && i == 0) alu_valid = 1'b0;
      e = sb.pop_front();
      total_cnt++;
      if (rf_load !== e.load || rf_w_address !== e.addr || rf_w_in !== e.data)
        $display("FAIL reset_after_write[%0d]: got %b/%0d/%h want %b/%0d/%h",
                 i, rf_load, rf_w_address, rf_w_in, e.load, e.addr, e.data);
      else pass_cnt++;
      if (i == 0) alu_valid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_conflict();
    wr_t        e;
    logic [4:0] want_addr;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if ({mem_ready, alu_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL conflict_grant[%0d]: got %b want %b", i, {mem_ready, alu_ready},
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      else pass_cnt++;
      tick();
      e = sb.pop_front();
      want_addr = (i % 2 == 0) ? 5'd1 : 5'd2;
      total_cnt++;
      if (rf_load !== 1'b1 || rf_w_address !== want_addr || rf_w_address !== e.addr ||
          rf_w_in !== e.data)
        $display("FAIL conflict_write[%0d]: got %b/%0d/%h want 1/%0d/%h",
                 i, rf_load, rf_w_address, rf_w_in, want_addr, e.data);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_single();
    wr_t e;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
    #1;
    total_cnt++;
    if ({mem_ready, alu_ready} !== 2'b01)
      $display("FAIL single_ready: got %b want 01", {mem_ready, alu_ready});
    else pass_cnt++;
    tick();
    idle_inputs();
    e = sb.pop_front();
    total_cnt++;
    if (rf_load !== 1'b1 || rf_w_address !== 5'd5 || rf_w_in !== 32'hAA || e.load !== 1'b1)
      $display("FAIL single_write: got %b/%0d/%h want 1/5/000000aa",
               rf_load, rf_w_address, rf_w_in);
    else pass_cnt++;
    tick();
    e = sb.pop_front();
    total_cnt++;
    if (rf_load !== 1'b0)
      $display("FAIL single_idle_load: got %b want 0", rf_load);
    else pass_cnt++;
  endtask

  task automatic test_fixed_prio();
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (fp_mem_ready !== 1'b1 || fp_alu_ready !== 1'b0)
        $display("FAIL fixed_prio_grant[%0d]: got mem=%b alu=%b want mem=1 alu=0",
                 i, fp_mem_ready, fp_alu_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (fp_rf_load !== 1'b1 || fp_rf_w_address !== 5'd10)
        $display("FAIL fixed_prio_write[%0d]: got %b/%0d want 1/10",
                 i, fp_rf_load, fp_rf_w_address);
      else pass_cnt++;
    end
    mem_valid = 1'b0;
    #1;
    total_cnt++;
    if (fp_alu_ready !== 1'b1 || fp_mem_ready !== 1'b0)
      $display("FAIL fixed_prio_alu_after: got alu=%b mem=%b want alu=1 mem=0",
               fp_alu_ready, fp_mem_ready);
    else pass_cnt++;
    tick();
    idle_inputs();
    total_cnt++;
    if (fp_rf_load !== 1'b1 || fp_rf_w_address !== 5'd9 || fp_rf_w_in !== 32'h99)
      $display("FAIL fixed_prio_alu_write: got %b/%0d/%h want 1/9/00000099",
               fp_rf_load, fp_rf_w_address, fp_rf_w_in);
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_x0();
    wr_t e;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD_BEEF;
    #1;
    total_cnt++;
    if (mem_ready !== 1'b1)
      $display("FAIL x0_ready: got %b want 1", mem_ready);
    else pass_cnt++;
    tick();
    idle_inputs();
    q1_addr = 5'd0;
    #1;
    e = sb.pop_front();
    total_cnt++;
    if (rf_load !== e.load || rf_load !== 1'b0)
      $display("FAIL x0_rf_load: got %b want 0", rf_load);
    else pass_cnt++;
    total_cnt++;
    if (q1_hit !== 1'b0)
      $display("FAIL x0_q1_hit: got %b want 0", q1_hit);
    else pass_cnt++;
  endtask

  task automatic test_fwd_reset();
    wr_t e;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234;
    tick();
    idle_inputs();
    e = sb.pop_front();
    q1_addr = 5'd7; q2_addr = 5'd8;
    #1;
    total_cnt++;
    if (q1_hit !== 1'b1 || fwd_data !== 32'h1234 || fwd_data !== e.data)
      $display("FAIL fwd_q1: got hit=%b data=%h want hit=1 data=00001234", q1_hit, fwd_data);
    else pass_cnt++;
    total_cnt++;
    if (q2_hit !== 1'b0)
      $display("FAIL fwd_q2: got %b want 0", q2_hit);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    e = sb.pop_front();
    total_cnt++;
    if (rf_load !== 1'b0 || rf_load !== e.load || q1_hit !== 1'b0)
      $display("FAIL reset_mid_op: got load=%b hit=%b want load=0 hit=0", rf_load, q1_hit);
    else pass_cnt++;
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hD0;
    #1;
    total_cnt++;
    if ({mem_ready, alu_ready} !== 2'b01)
      $display("FAIL reset_last_grant: got %b want 01", {mem_ready, alu_ready});
    else pass_cnt++;
    tick();
    idle_inputs();
    e = sb.pop_front();
    total_cnt++;
    if (rf_load !== 1'b1 || rf_w_address !== 5'd12 || rf_w_in !== 32'hC0)
      $display("FAIL reset_rewrite: got %b/%0d/%h want 1/12/000000c0",
               rf_load, rf_w_address, rf_w_in);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    wr_t        e;
    logic [1:0] g;
    for (int i = 0; i < 60; i++) begin
      #1;
      g = model_grant();
      total_cnt++;
      if ({mem_ready, alu_ready} !== g)
        $display("FAIL b2b_grant[%0d]: got %b want %b", i, {mem_ready, alu_ready}, g);
      else pass_cnt++;
      tick();
      e = sb.pop_front();
      total_cnt++;
      if (rf_load !== e.load || (e.load && (rf_w_address !== e.addr || rf_w_in !== e.data)))
        $display("FAIL b2b_write[%0d]: got %b/%0d/%h want %b/%0d/%h",
                 i, rf_load, rf_w_address, rf_w_in, e.load, e.addr, e.data);
      else pass_cnt++;
      // A source only changes its request once it has been accepted.
      if (!alu_valid || g[0]) begin
        alu_valid = ($urandom_range(3, 0) != 0);
        alu_rd    = 5'($urandom_range(31, 0));
        alu_data  = $urandom;
      end
      if (!mem_valid || g[1]) begin
        mem_valid = ($urandom_range(3, 0) != 0);
        mem_rd    = 5'($urandom_range(31, 0));
        mem_data  = $urandom;
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_last = 1'b1;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_conflict();
    test_single();
    test_fixed_prio();
    test_x0();
    test_fwd_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
